// File: rtl/axi_vdma_pkg.sv
// Shared definitions for the VDMA write path: beat geometry and the
// burst-scheduler FSM encoding.
package axi_vdma_pkg;

  localparam int BEAT_BYTES = 32;
  localparam int BEAT_SHIFT = 5;
  localparam int PAGE_BEATS = 128;

  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_CALC = 4'd1;
  localparam logic [3:0] ST_REQ  = 4'd2;
  localparam logic [3:0] ST_WAIT = 4'd3;
  localparam logic [3:0] ST_FIN  = 4'd4;

  typedef enum logic [3:0] {
    S_IDLE = ST_IDLE,
    S_CALC = ST_CALC,
    S_REQ  = ST_REQ,
    S_WAIT = ST_WAIT,
    S_FIN  = ST_FIN
  } wr_state_e;

endpackage

// File: rtl/axi_burst_len_calc.sv
// Burst length selector: the largest INCR burst that neither exceeds the
// beats left, the configured burst cap, nor the end of the 4 KB page.
module axi_burst_len_calc
  import axi_vdma_pkg::*;
#(
  parameter int BSIZE     = 24,
  parameter int MAX_BURST = 64
) (
  input  logic [6:0]       page_beat,
  input  logic [BSIZE-1:0] remaining,
  output logic [7:0]       blen
);

  logic [7:0] to_boundary;
  logic [7:0] cap;

  // min(remaining, MAX_BURST, to_boundary); remaining is compared at full
  // width so a large transfer never aliases to a short burst.
  always_comb begin
    to_boundary = 8'(PAGE_BEATS) - {1'b0, page_beat};
    cap         = (8'(MAX_BURST) < to_boundary) ? 8'(MAX_BURST) : to_boundary;
    if (remaining < BSIZE'(cap)) begin
      blen = remaining[7:0];
    end else begin
      blen = cap;
    end
  end

endmodule

// File: rtl/axi_wr_burst_scheduler.sv
// Splits one frame-segment write into 4 KB-safe INCR bursts and hands them
// to the AXI write core one at a time.
module axi_wr_burst_scheduler
  import axi_vdma_pkg::*;
#(
  parameter int ASIZE     = 32,
  parameter int LSIZE     = 10,
  parameter int BSIZE     = 24,
  parameter int MAX_BURST = 64
) (
  input  logic             axi_aclk,
  input  logic             axi_rst,
  input  logic             start,
  input  logic [ASIZE-1:0] cfg_addr,
  input  logic [BSIZE-1:0] cfg_beats,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [15:0]      burst_cnt,
  output logic             write_req,
  output logic [ASIZE-1:0] req_addr,
  output logic [LSIZE-1:0] req_len,
  input  logic             req_resp,
  input  logic             req_done,
  input  logic             req_err
);

  wr_state_e        state_q, state_d;
  logic [ASIZE-1:0] cur_addr_q, cur_addr_d;
  logic [BSIZE-1:0] remaining_q, remaining_d;
  logic [7:0]       blen_q, blen_d;
  logic [7:0]       blen_calc;
  logic [7:0]       blen_m1;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [15:0]      burst_cnt_q, burst_cnt_d;
  logic             write_req_q, write_req_d;
  logic [ASIZE-1:0] req_addr_q, req_addr_d;
  logic [LSIZE-1:0] req_len_q, req_len_d;

  axi_burst_len_calc #(
    .BSIZE     (BSIZE),
    .MAX_BURST (MAX_BURST)
  ) u_len_calc (
    .page_beat (cur_addr_q[11:5]),
    .remaining (remaining_q),
    .blen      (blen_calc)
  );

  assign blen_m1 = blen_calc - 8'd1;

  // Next-state and next-output logic; outputs are derived from the next
  // state so every port is driven straight from a flop.
  always_comb begin
    // NOTE: every _d gets a default first, so no path leaves one unassigned
    // and no latch is inferred; blocking '=' is correct in combinational code.
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    blen_d      = blen_q;
    err_d       = err_q;
    burst_cnt_d = burst_cnt_q;
    req_addr_d  = req_addr_q;
    req_len_d   = req_len_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cur_addr_d  = cfg_addr & ~ASIZE'(BEAT_BYTES - 1);
          remaining_d = cfg_beats;
          err_d       = 1'b0;
          burst_cnt_d = 16'd0;
          state_d     = (cfg_beats == '0) ? S_FIN : S_CALC;
        end
      end
      S_CALC: begin
        req_addr_d = cur_addr_q;
        req_len_d  = LSIZE'(blen_m1);
        blen_d     = blen_calc;
        state_d    = S_REQ;
      end
      S_REQ: begin
        // A req_done coinciding with req_resp is deliberately not looked at.
        if (req_resp) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (req_done) begin
          cur_addr_d  = cur_addr_q + (ASIZE'(blen_q) << BEAT_SHIFT);
          remaining_d = remaining_q - BSIZE'(blen_q);
          burst_cnt_d = burst_cnt_q + 16'd1;
          if (req_err) begin
            err_d   = 1'b1;
            state_d = S_FIN;
          end else if (remaining_d == '0) begin
            state_d = S_FIN;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_FIN);
    write_req_d = (state_d == S_REQ);
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge axi_aclk) begin
    // NOTE: sequential state uses non-blocking '<=' so all flops update
    // together at the edge, independent of statement order.
    if (axi_rst) begin
      state_q     <= S_IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      blen_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      burst_cnt_q <= '0;
      write_req_q <= 1'b0;
      req_addr_q  <= '0;
      req_len_q   <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      blen_q      <= blen_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      burst_cnt_q <= burst_cnt_d;
      write_req_q <= write_req_d;
      req_addr_q  <= req_addr_d;
      req_len_q   <= req_len_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign burst_cnt = burst_cnt_q;
  assign write_req = write_req_q;
  assign req_addr  = req_addr_q;
  assign req_len   = req_len_q;

endmodule

// File: tb/tb_axi_wr_burst_scheduler.sv
// Bench for axi_wr_burst_scheduler: a split model feeds an expected-burst
// queue, a responder plays the write core, a monitor compares every burst.
module tb_axi_wr_burst_scheduler;

  localparam int ASIZE     = 32;
  localparam int LSIZE     = 10;
  localparam int BSIZE     = 24;
  localparam int MAX_BURST = 64;

  typedef struct {
    logic [ASIZE-1:0] addr;
    logic [LSIZE-1:0] len;
  } burst_t;

  logic             axi_aclk = 1'b0;
  logic             axi_rst  = 1'b1;
  logic             start    = 1'b0;
  logic [ASIZE-1:0] cfg_addr = '0;
  logic [BSIZE-1:0] cfg_beats = '0;
  logic             busy, done, err, write_req;
  logic [15:0]      burst_cnt;
  logic [ASIZE-1:0] req_addr;
  logic [LSIZE-1:0] req_len;
  logic             req_resp = 1'b0;
  logic             req_done = 1'b0;
  logic             req_err  = 1'b0;

  axi_wr_burst_scheduler #(
    .ASIZE(ASIZE), .LSIZE(LSIZE), .BSIZE(BSIZE), .MAX_BURST(MAX_BURST)
  ) dut (
    .axi_aclk  (axi_aclk),
    .axi_rst   (axi_rst),
    .start     (start),
    .cfg_addr  (cfg_addr),
    .cfg_beats (cfg_beats),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .burst_cnt (burst_cnt),
    .write_req (write_req),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .req_resp  (req_resp),
    .req_done  (req_done),
    .req_err   (req_err)
  );

  always #5 axi_aclk = ~axi_aclk;

  int n_checks = 0;
  int n_errors = 0;

  burst_t exp_q[$];
  burst_t mdl_q[$];

  // Responder configuration and bookkeeping.
  int resp_delay  = 0;
  int done_delay  = 2;
  int err_idx     = -1;
  int burst_idx   = 0;
  int done_pulses = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference split: walk the transfer, cutting at the burst cap and at
  // every 4 KB page end.
  function automatic void model_split(input longint a, input longint b);
    longint addr = a & ~longint'(31);
    longint rem  = b;
    longint room, bl;
    burst_t e;
    mdl_q.delete();
    while (rem > 0) begin
      room = 128 - ((addr / 32) % 128);
      bl   = rem;
      if (bl > MAX_BURST) bl = MAX_BURST;
      if (bl > room) bl = room;
      e.addr = ASIZE'(addr);
      e.len  = LSIZE'(bl - 1);
      mdl_q.push_back(e);
      addr = (addr + bl * 32) % 64'h1_0000_0000;
      rem  = rem - bl;
    end
  endfunction

  // Write-core stand-in: accept after resp_delay cycles, finish after
  // done_delay more; flag an error on the burst numbered err_idx.
  initial begin
    int phase = 0;
    int cnt   = 0;
    forever begin
      @(negedge axi_aclk);
      req_resp = 1'b0;
      req_done = 1'b0;
      req_err  = 1'b0;
      if (axi_rst) begin
        phase = 0;
      end else begin
        if (phase == 0 && write_req) begin
          phase = 1;
          cnt   = resp_delay;
        end
        if (phase == 1) begin
          if (cnt == 0) begin
            req_resp = 1'b1;
            phase    = 2;
            cnt      = done_delay;
          end else begin
            cnt--;
          end
        end else if (phase == 2) begin
          if (cnt == 0) begin
            req_done = 1'b1;
            req_err  = (burst_idx == err_idx);
            burst_idx++;
            phase = 0;
          end else begin
            cnt--;
          end
        end
      end
    end
  end

  // Compare process: each new request must be the next modelled burst and
  // must stay stable and held until the core accepts it.
  initial begin
    logic   wr_prev = 1'b0;
    burst_t held;
    int     held_cycles = 0;
    held.addr = '0;
    held.len  = '0;
    forever begin
      @(negedge axi_aclk);
      if (done) done_pulses++;
      if (req_resp && req_done) check("resp_done_overlap", 1, 0);
      if (write_req && !wr_prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write_req", 1, 0);
        end else begin
          held = exp_q.pop_front();
          check("req_addr", req_addr, held.addr);
          check("req_len", req_len, held.len);
        end
        held_cycles = 1;
      end else if (write_req) begin
        held_cycles++;
        check("req_addr_stable", req_addr, held.addr);
        check("req_len_stable", req_len, held.len);
      end else if (wr_prev) begin
        check("write_req_hold_cycles", held_cycles, resp_delay + 1);
      end
      wr_prev = write_req;
    end
  end

  // Queue the modelled bursts (only the first n_push if n_push >= 0) and
  // pulse start; returns in cycle 1 of the transfer.
  task automatic launch(input logic [ASIZE-1:0] a, input logic [BSIZE-1:0] b, input int n_push);
    model_split(a, b);
    for (int i = 0; i < mdl_q.size(); i++) begin
      if (n_push < 0 || i < n_push) exp_q.push_back(mdl_q[i]);
    end
    @(negedge axi_aclk);
    cfg_addr  = a;
    cfg_beats = b;
    start     = 1'b1;
    @(negedge axi_aclk);
    start = 1'b0;
  endtask

  task automatic run_xfer(input logic [ASIZE-1:0] a, input logic [BSIZE-1:0] b,
                          input int n_push, output int t_done, output int t_first,
                          output int busy_cycles);
    int t = 1;
    t_done      = -1;
    t_first     = -1;
    busy_cycles = 0;
    launch(a, b, n_push);
    while (t < 2000) begin
      if (write_req && t_first < 0) t_first = t;
      if (busy) busy_cycles++;
      if (done) begin
        t_done = t;
        break;
      end
      @(negedge axi_aclk);
      t++;
    end
    check("done_seen", (t_done >= 0), 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_burst_cnt"}, burst_cnt, 0);
    check({tag, "_write_req"}, write_req, 0);
    check({tag, "_req_addr"}, req_addr, 0);
    check({tag, "_req_len"}, req_len, 0);
  endtask

  // Global guard against a hung run.
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t_done, t_first, busy_cycles, d0, b0;

    repeat (3) @(negedge axi_aclk);
    check_all_zero("reset");
    axi_rst = 1'b0;
    @(negedge axi_aclk);

    // Pin the model against hand-split literals.
    model_split(32'h0FC0, 10);
    check("model_n_boundary", mdl_q.size(), 2);
    check("model_b0_addr", mdl_q[0].addr, 32'h0FC0);
    check("model_b0_len", mdl_q[0].len, 1);
    check("model_b1_addr", mdl_q[1].addr, 32'h1000);
    check("model_b1_len", mdl_q[1].len, 7);
    model_split(32'h0, 150);
    check("model_n_max", mdl_q.size(), 3);
    check("model_m1_addr", mdl_q[1].addr, 32'h0800);
    check("model_m2_len", mdl_q[2].len, 21);

    // Boundary split.
    d0 = done_pulses;
    run_xfer(32'h0FC0, 24'd10, -1, t_done, t_first, busy_cycles);
    check("bnd_first_write_req_cycle", t_first, 2);
    check("bnd_done_cycle", t_done, 11);
    check("bnd_burst_cnt", burst_cnt, 2);
    check("bnd_err", err, 0);
    @(negedge axi_aclk);
    check("bnd_busy_after_done", busy, 0);
    check("bnd_done_pulses", done_pulses - d0, 1);
    check("bnd_queue_drained", exp_q.size(), 0);

    // Max-burst split.
    run_xfer(32'h0, 24'd150, -1, t_done, t_first, busy_cycles);
    check("max_burst_cnt", burst_cnt, 3);
    check("max_err", err, 0);
    @(negedge axi_aclk);
    check("max_queue_drained", exp_q.size(), 0);

    // Empty transfer.
    d0 = done_pulses;
    run_xfer(32'h1234, 24'd0, -1, t_done, t_first, busy_cycles);
    check("empty_done_cycle", t_done, 1);
    check("empty_busy_cycles", busy_cycles, 1);
    check("empty_no_write_req", t_first, -1);
    check("empty_burst_cnt", burst_cnt, 0);
    @(negedge axi_aclk);
    check("empty_done_pulses", done_pulses - d0, 1);

    // Error abort on the second burst; only two bursts may ever appear.
    b0      = burst_idx;
    err_idx = b0 + 1;
    d0      = done_pulses;
    run_xfer(32'h0, 24'd200, 2, t_done, t_first, busy_cycles);
    check("abort_err", err, 1);
    check("abort_burst_cnt", burst_cnt, 2);
    repeat (10) @(negedge axi_aclk);
    check("abort_bursts_issued", burst_idx - b0, 2);
    check("abort_done_pulses", done_pulses - d0, 1);
    check("abort_err_sticky", err, 1);
    err_idx = -1;

    // Backpressure with a stray start mid-transfer.
    resp_delay = 7;
    fork
      run_xfer(32'h3000, 24'd100, -1, t_done, t_first, busy_cycles);
      begin
        repeat (4) @(negedge axi_aclk);
        cfg_addr  = 32'h5000;
        cfg_beats = 24'd7;
        start     = 1'b1;
        @(negedge axi_aclk);
        start = 1'b0;
      end
    join
    check("bp_err_cleared", err, 0);
    check("bp_burst_cnt", burst_cnt, 2);
    repeat (5) @(negedge axi_aclk);
    check("bp_queue_drained", exp_q.size(), 0);
    check("bp_idle_after_stray", busy, 0);
    resp_delay = 0;

    // Reset while the core is busy with a burst.
    done_delay = 20;
    launch(32'h0, 24'd64, -1);
    begin
      int  n    = 0;
      logic seen = 1'b0;
      while (n < 50 && !(seen && !write_req)) begin
        if (write_req) seen = 1'b1;
        @(negedge axi_aclk);
        n++;
      end
      check("rst_reached_wait", (n < 50), 1);
    end
    repeat (2) @(negedge axi_aclk);
    #1 axi_rst = 1'b1;
    @(negedge axi_aclk);
    check_all_zero("midrst");
    #1 axi_rst = 1'b0;
    exp_q.delete();
    done_delay = 2;
    @(negedge axi_aclk);
    run_xfer(32'h2000, 24'd4, -1, t_done, t_first, busy_cycles);
    check("post_rst_first_write_req", t_first, 2);
    check("post_rst_done_cycle", t_done, 6);
    check("post_rst_burst_cnt", burst_cnt, 1);
    check("post_rst_err", err, 0);
    @(negedge axi_aclk);
    check("post_rst_queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
